// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: streams host configuration words MSB-first into a serial
// configuration flip-flop chain and keeps a CRC-16 of every bit shifted.
// Optional readback verification is compiled in with the macro
// CCFF_CHAIN_LOADER_READBACK_EN. When it is enabled, the chain is recirculated
// once through its tail and a second CRC is compared against the load CRC.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 42,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // The bit counter is 16 bits wide because CHAIN_LEN can be as large as 65535.
    localparam logic [15:0] LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [5:0]  LAST_WBIT = 6'(WORD_W - 1);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, VERIFY, DONE} state_t;
`else
    typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DONE} state_t;
`endif

    // Serial CRC-16 step: polynomial 0x1021, no reflection.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t            state;
    logic [WORD_W-1:0] word;      // current word; its MSB always drives the head
    logic [15:0]       bit_cnt;   // bits shifted in this load
    logic [5:0]        word_cnt;  // bits shifted from the current word
    logic [15:0]       crc;       // CRC of the bits that were loaded

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    logic [15:0] vcnt;            // recirculation cycles completed
    logic [15:0] crc_rb;          // CRC of the bits read back from the tail
    logic        error_q;
`endif

    // Load sequencer. A partial last word leaves SHIFT as soon as the chain
    // is full, so its low-order bits are never presented to the chain.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state    <= IDLE;
            word     <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            crc      <= 16'hFFFF;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
            vcnt     <= '0;
            crc_rb   <= 16'hFFFF;
            error_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= FETCH;
                        bit_cnt <= '0;
                        crc     <= 16'hFFFF;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                        vcnt    <= '0;
                        crc_rb  <= 16'hFFFF;
                        error_q <= 1'b0;
`endif
                    end
                end
                FETCH: begin
                    if (cfg_valid) begin
                        word     <= cfg_data;
                        word_cnt <= '0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    crc      <= crc_step(crc, word[WORD_W-1]);
                    word     <= word << 1;
                    bit_cnt  <= bit_cnt + 16'd1;
                    word_cnt <= word_cnt + 6'd1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                        state <= VERIFY;
`else
                        state <= DONE;
`endif
                    end else if (word_cnt == LAST_WBIT) begin
                        state <= FETCH;
                    end
                end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
                VERIFY: begin
                    crc_rb <= crc_step(crc_rb, ccff_tail);
                    vcnt   <= vcnt + 16'd1;
                    if (vcnt == LAST_BIT) begin
                        state   <= DONE;
                        error_q <= (crc_step(crc_rb, ccff_tail) != crc);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (state == FETCH);
    assign done      = (state == DONE);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    // During readback the tail is looped back to the head, so the chain
    // contents are back in place after CHAIN_LEN shifts.
    assign busy          = (state == FETCH) || (state == SHIFT) || (state == VERIFY);
    assign ccff_shift_en = (state == SHIFT) || (state == VERIFY);
    assign ccff_head     = (state == SHIFT)  ? word[WORD_W-1] :
                           (state == VERIFY) ? ccff_tail      : 1'b0;
    assign error         = error_q;
`else
    logic unused_tail;
    assign unused_tail   = ccff_tail;
    assign busy          = (state == FETCH) || (state == SHIFT);
    assign ccff_shift_en = (state == SHIFT);
    assign ccff_head     = (state == SHIFT) && word[WORD_W-1];
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: drives a 42-FF chain model. It runs a table of
// directed loads, a reset-abort sequence, and random loads that are checked
// against a bit-queue reference model.
module tb_ccff_chain_loader;
    localparam int CHAIN_LEN = 42;
    localparam int WORD_W    = 8;
    localparam int NEEDED    = (CHAIN_LEN + WORD_W - 1) / WORD_W;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif
    localparam logic [CHAIN_LEN-1:0] BASE_BITS = 42'b10100101_00111100_11111111_00000000_10000001_11;
    localparam logic [CHAIN_LEN-1:0] FLIP_MASK = 42'd1 << 17;

    logic              prog_clk = 1'b0;
    logic              pReset, start, cfg_valid, ccff_tail;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready, ccff_head, ccff_shift_en, busy, done, error;
    logic              flip_req;
    logic [CHAIN_LEN-1:0] chain = '0;

    int errors = 0;
    int checks = 0;

    logic [WORD_W-1:0] cur_words[$];
    int                cur_gaps[$];
    logic              bits[$];

    typedef struct {
        string                name;
        int                   gap;
        int                   start_at;
        bit                   flip;
        logic [CHAIN_LEN-1:0] exp_bits;
        logic                 exp_err;
    } vec_t;
    vec_t tbl[4];

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN), .WORD_W(WORD_W)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .error(error)
    );

    always #5 prog_clk = ~prog_clk;

    // Ideal chain: shifts toward the tail; flip_req corrupts bit 17.
    always @(posedge prog_clk)
        chain <= (ccff_shift_en ? {chain[CHAIN_LEN-2:0], ccff_head} : chain)
                 ^ (flip_req ? FLIP_MASK : '0);
    assign ccff_tail = chain[CHAIN_LEN-1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the first CHAIN_LEN bits of the word stream, MSB first.
    function automatic logic [CHAIN_LEN-1:0] model_bits();
        logic [CHAIN_LEN-1:0] v;
        int k;
        v = '0;
        k = 0;
        foreach (cur_words[i])
            for (int b = WORD_W - 1; b >= 0; b--) begin
                if (k < CHAIN_LEN) v[CHAIN_LEN-1-k] = cur_words[i][b];
                k++;
            end
        return v;
    endfunction

    task automatic run_load(input string tag, input int start_at, input int abort_at,
                            input bit flip, input logic exp_err,
                            input logic [CHAIN_LEN-1:0] exp_v);
        int idx, gapleft, busy_n, cycles, exp_busy;
        bit got_done, start_sent;
        logic bad;
        logic [CHAIN_LEN-1:0] load_v, rb_v;
        bits.delete();
        cfg_valid = 0;
        @(negedge prog_clk); start = 1;
        @(negedge prog_clk); start = 0;
        idx = 0; gapleft = -1; busy_n = 0; cycles = 0; got_done = 0; start_sent = 0;
        while (cycles < 1000) begin
            if (ccff_shift_en) bits.push_back(ccff_head);
            if (busy) busy_n++;
            if (done) begin got_done = 1; break; end
            if (abort_at > 0 && bits.size() == abort_at + 1) begin
                pReset = 1; cfg_valid = 0; start = 0; flip_req = 0;
                return;
            end
            start = 0;
            if (start_at >= 0 && !start_sent && bits.size() == start_at) begin
                start = 1; start_sent = 1;
            end
            flip_req = flip && (bits.size() == CHAIN_LEN);
            if (cfg_ready && idx < cur_words.size()) begin
                if (gapleft < 0) gapleft = cur_gaps[idx];
                if (gapleft > 0) begin
                    cfg_valid = 0; gapleft--;
                end else begin
                    cfg_valid = 1; cfg_data = cur_words[idx]; idx++; gapleft = -1;
                end
            end else cfg_valid = 0;
            @(negedge prog_clk);
            cycles++;
        end
        start = 0; flip_req = 0; cfg_valid = 0;
        exp_busy = CHAIN_LEN * (RB ? 2 : 1);
        for (int i = 0; i < NEEDED; i++) exp_busy += 1 + cur_gaps[i];
        load_v = '0; rb_v = '0;
        for (int k = 0; k < CHAIN_LEN; k++) begin
            if (k < bits.size()) load_v[CHAIN_LEN-1-k] = bits[k];
            if (k + CHAIN_LEN < bits.size()) rb_v[CHAIN_LEN-1-k] = bits[k+CHAIN_LEN];
        end
        chk({tag, ".done_seen"}, 64'(got_done), 64'd1);
        chk({tag, ".words_accepted"}, 64'(idx), 64'(NEEDED));
        chk({tag, ".shift_count"}, 64'(bits.size()), 64'(CHAIN_LEN * (RB ? 2 : 1)));
        chk({tag, ".load_bits"}, 64'(load_v), 64'(exp_v));
        if (RB && !flip) chk({tag, ".readback_bits"}, 64'(rb_v), 64'(exp_v));
        chk({tag, ".busy_cycles"}, 64'(busy_n), 64'(exp_busy));
        chk({tag, ".error"}, 64'(error), 64'(exp_err));
        if (!flip) chk({tag, ".chain"}, 64'(chain), 64'(exp_v));
        // In DONE the loader must refuse further words and hold done.
        bad = 0;
        cfg_valid = 1;
        repeat (3) begin
            @(negedge prog_clk);
            bad = bad | cfg_ready | ccff_shift_en | ~done;
        end
        cfg_valid = 0;
        chk({tag, ".done_hold"}, 64'(bad), 64'd0);
    endtask

    task automatic set_base(input int gap);
        cur_words = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hC0};
        cur_gaps.delete();
        for (int i = 0; i < 7; i++) cur_gaps.push_back(gap);
    endtask

    initial begin
        tbl[0] = '{"held",        0, -1, 1'b0, BASE_BITS, 1'b0};
        tbl[1] = '{"gap5",        5, -1, 1'b0, BASE_BITS, 1'b0};
        tbl[2] = '{"start_shift", 1, 13, 1'b0, BASE_BITS, 1'b0};
        tbl[3] = '{"flip17",      0, -1, 1'b1, BASE_BITS, RB};

        pReset = 1; start = 0; cfg_valid = 0; cfg_data = '0; flip_req = 0;
        repeat (3) @(negedge prog_clk);
        chk("rst.cfg_ready", 64'(cfg_ready), 64'd0);
        chk("rst.shift_en",  64'(ccff_shift_en), 64'd0);
        chk("rst.head",      64'(ccff_head), 64'd0);
        chk("rst.busy",      64'(busy), 64'd0);
        chk("rst.done",      64'(done), 64'd0);
        chk("rst.error",     64'(error), 64'd0);
        pReset = 0;
        @(negedge prog_clk);

        for (int t = 0; t < 4; t++) begin
            set_base(tbl[t].gap);
            run_load(tbl[t].name, tbl[t].start_at, 0, tbl[t].flip, tbl[t].exp_err, tbl[t].exp_bits);
        end

        // Reset in the middle of the third word, then a clean reload.
        set_base(0);
        run_load("abort", -1, 20, 1'b0, 1'b0, BASE_BITS);
        @(negedge prog_clk);
        chk("abort.cfg_ready", 64'(cfg_ready), 64'd0);
        chk("abort.shift_en",  64'(ccff_shift_en), 64'd0);
        chk("abort.head",      64'(ccff_head), 64'd0);
        chk("abort.busy",      64'(busy), 64'd0);
        chk("abort.done",      64'(done), 64'd0);
        chk("abort.error",     64'(error), 64'd0);
        pReset = 0;
        @(negedge prog_clk);
        run_load("reload", -1, 0, 1'b0, 1'b0, BASE_BITS);

        // Random streams carry one surplus word that must never be taken.
        for (int r = 0; r < 4; r++) begin
            cur_words.delete(); cur_gaps.delete();
            for (int i = 0; i < NEEDED + 1; i++) begin
                cur_words.push_back(WORD_W'($urandom));
                cur_gaps.push_back(int'($urandom_range(0, 3)));
            end
            run_load($sformatf("rand%0d", r), -1, 0, 1'b0, 1'b0, model_bits());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
